// File: rtl/udma_filter_sched_pkg.sv
// udma_filter_sched_pkg: shared FSM state type and cfg bus widths for the uDMA filter scheduler
package udma_filter_sched_pkg;
    typedef enum logic [1:0] {IDLE, CFG, START, WAIT} state_t;
    localparam int CFG_AW = 5;
    localparam int CFG_DW = 32;
endpackage

// File: rtl/udma_filter_sched_rr_arb.sv
// udma_filter_sched_rr_arb: combinational round-robin arbiter, first request at or after ptr wins
module udma_filter_sched_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);
    logic [2*NREQ-1:0] dbl;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;
    // rotate requests so ptr sits at bit 0, pick the lowest set bit, then rotate the index back
    always_comb begin
        dbl = {req, req} >> ptr;
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) off = dbl[i] ? IDW'(i) : off;
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
        gnt = (|req) ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/udma_filter_sched.sv
// udma_filter_sched: shares one uDMA filter among requesters, copying the winner's descriptor over the cfg bus
module udma_filter_sched
    import udma_filter_sched_pkg::*;
#(
    parameter int                 NREQ       = 4,
    parameter int                 IDW        = 2,
    parameter int                 NWORDS     = 8,
    parameter logic [CFG_AW-1:0]  START_ADDR = 5'h1F,
    parameter logic [CFG_DW-1:0]  START_DATA = 32'h1,
    parameter int                 TO_W       = 20
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NREQ-1:0]               req_valid_i,
    input  logic [NREQ*NWORDS*CFG_DW-1:0] req_desc_i,
    output logic [NREQ-1:0]               req_ready_o,
    output logic [NREQ-1:0]               done_o,
    output logic [NREQ-1:0]               err_o,
    output logic                          busy_o,
    output logic [IDW-1:0]                cur_id_o,
    input  logic [TO_W-1:0]               timeout_i,
    input  logic                          abort_i,
    output logic [CFG_AW-1:0]             cfg_addr_o,
    output logic [CFG_DW-1:0]             cfg_data_o,
    output logic                          cfg_valid_o,
    output logic                          cfg_rwn_o,
    input  logic                          cfg_ready_i,
    input  logic                          eot_event_i
);
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_t                        state;
    logic [IDW-1:0]                rr_ptr;
    logic [IDW-1:0]                gidx;
    logic [NREQ-1:0]               gnt;
    logic [NWORDS-1:0][CFG_DW-1:0] desc;
    logic [KW-1:0]                 k;
    logic [TO_W-1:0]               to_cnt;
    logic                          abort_q;
    logic                          beat;
    logic                          abort_now;

    udma_filter_sched_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req (req_valid_i),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx)
    );

    assign req_ready_o = (state == IDLE && !rst_i) ? gnt : '0;
    assign busy_o      = state != IDLE;
    assign cfg_rwn_o   = 1'b0;
    assign beat        = cfg_valid_o & cfg_ready_i;
    assign abort_now   = abort_q | abort_i;

    // job FSM: grant, stream descriptor words, write start, then wait for eot / timeout / abort
    always_ff @(posedge clk_i) begin
        done_o <= '0;
        err_o  <= '0;
        if (rst_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_id_o    <= '0;
            desc        <= '0;
            k           <= '0;
            to_cnt      <= '0;
            abort_q     <= 1'b0;
            cfg_valid_o <= 1'b0;
            cfg_addr_o  <= '0;
            cfg_data_o  <= '0;
        end else begin
            case (state)
                IDLE: if (|req_ready_o) begin
                    desc        <= req_desc_i[gidx*NWORDS*CFG_DW +: NWORDS*CFG_DW];
                    cur_id_o    <= gidx;
                    rr_ptr      <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
                    k           <= '0;
                    abort_q     <= 1'b0;
                    cfg_valid_o <= 1'b1;
                    cfg_addr_o  <= '0;
                    cfg_data_o  <= req_desc_i[gidx*NWORDS*CFG_DW +: CFG_DW];
                    state       <= CFG;
                end
                CFG: begin
                    abort_q <= abort_now;
                    if (beat) begin
                        if (abort_now) begin
                            cfg_valid_o <= 1'b0;
                            err_o       <= NREQ'(1) << cur_id_o;
                            abort_q     <= 1'b0;
                            state       <= IDLE;
                        end else if (k == KW'(NWORDS - 1)) begin
                            cfg_addr_o <= START_ADDR;
                            cfg_data_o <= START_DATA;
                            state      <= START;
                        end else begin
                            k          <= k + KW'(1);
                            cfg_addr_o <= CFG_AW'(k + KW'(1));
                            cfg_data_o <= desc[k + KW'(1)];
                        end
                    end
                end
                START: begin
                    abort_q <= abort_now;
                    if (beat) begin
                        cfg_valid_o <= 1'b0;
                        abort_q     <= 1'b0;
                        to_cnt      <= '0;
                        err_o       <= abort_now ? NREQ'(1) << cur_id_o : '0;
                        state       <= abort_now ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (eot_event_i) begin
                        done_o <= NREQ'(1) << cur_id_o;
                        state  <= IDLE;
                    end else if (abort_i || (timeout_i != '0 && to_cnt == timeout_i - TO_W'(1))) begin
                        err_o <= NREQ'(1) << cur_id_o;
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
